// File: rtl/rdma_remap.sv
// RDMA local-to-remote address remapper: NUM_WIN programmable windows, lowest index wins,
// default rule XORs DEFAULT_XOR on a miss. Optional hit/miss counters under REMAP_STATS_EN.

module rdma_remap_win #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic [ADDR_W-1:0] cfg_xlat,
    input  logic [ADDR_W-1:0] addr,
    output logic              match,
    output logic [ADDR_W-1:0] xlat_addr
);
    logic              en;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] xlat;

    // Only the enable needs clearing; base/mask/xlat are don't-care while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b0;
        end else if (wr) begin
            en <= cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            base <= cfg_base;
            mask <= cfg_mask;
            xlat <= cfg_xlat;
        end
    end

    assign match     = en && ((addr & mask) == (base & mask));
    assign xlat_addr = (xlat & mask) | (addr & ~mask);
endmodule

module rdma_remap #(
    parameter int              ADDR_W      = 32,
    parameter int              NUM_WIN     = 4,
    parameter logic [ADDR_W-1:0] DEFAULT_XOR = 32'h8000_0000,
    localparam int             IDX_W       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] local_addr,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] remote_addr,
    output logic              out_valid,
    output logic              hit,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_mask,
`ifdef REMAP_STATS_EN
    input  logic [ADDR_W-1:0] cfg_xlat,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`else
    input  logic [ADDR_W-1:0] cfg_xlat
`endif
);
    typedef struct packed {
        logic              hit;
        logic [ADDR_W-1:0] addr;
    } resp_t;

    logic [NUM_WIN-1:0]             win_match;
    logic [NUM_WIN-1:0][ADDR_W-1:0] win_addr;
    resp_t                          lk;
    resp_t                          resp_q;
    logic                           vld_q;

    // Indices >= NUM_WIN never equal any instance index, so such writes are dropped.
    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        rdma_remap_win #(.ADDR_W(ADDR_W)) u_win (
            .clk       (clk),
            .rst       (rst),
            .wr        (cfg_we && (cfg_idx == IDX_W'(g))),
            .cfg_en    (cfg_en),
            .cfg_base  (cfg_base),
            .cfg_mask  (cfg_mask),
            .cfg_xlat  (cfg_xlat),
            .addr      (local_addr),
            .match     (win_match[g]),
            .xlat_addr (win_addr[g])
        );
    end

    // Walk from highest to lowest so the lowest matching index is the last to assign.
    always_comb begin
        lk.hit  = 1'b0;
        lk.addr = local_addr ^ DEFAULT_XOR;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_match[i]) begin
                lk.hit  = 1'b1;
                lk.addr = win_addr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                resp_q <= lk;
            end
        end
    end

    assign remote_addr = resp_q.addr;
    assign hit         = resp_q.hit;
    assign out_valid   = vld_q;

`ifdef REMAP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (in_valid) begin
            if (lk.hit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (!lk.hit && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rdma_remap.sv
// Directed bench for rdma_remap: default rule, window hits, priority, cfg timing, reset.
`timescale 1ns/1ps
module tb_rdma_remap;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] local_addr;
    logic        in_valid;
    logic [31:0] remote_addr;
    logic        out_valid;
    logic        hit;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [31:0] cfg_base;
    logic [31:0] cfg_mask;
    logic [31:0] cfg_xlat;
`ifdef REMAP_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rdma_remap dut (
        .clk         (clk),
        .rst         (rst),
        .local_addr  (local_addr),
        .in_valid    (in_valid),
        .remote_addr (remote_addr),
        .out_valid   (out_valid),
        .hit         (hit),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_base    (cfg_base),
        .cfg_mask    (cfg_mask),
`ifdef REMAP_STATS_EN
        .cfg_xlat    (cfg_xlat),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`else
        .cfg_xlat    (cfg_xlat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] a, input logic h, input logic v);
        check({tag, ".addr"}, remote_addr, a);
        check({tag, ".hit"}, {31'd0, hit}, {31'd0, h});
        check({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
    endtask

    task automatic set_win(input logic [1:0] idx, input logic en, input logic [31:0] b,
                           input logic [31:0] m, input logic [31:0] x);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_en   = en;
        cfg_base = b;
        cfg_mask = m;
        cfg_xlat = x;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; local_addr = 32'h0000_1000;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_base = '0; cfg_mask = '0; cfg_xlat = '0;
        tick(); tick();
        expect_out("reset", 32'h0, 1'b0, 1'b0);

        // 1: default rule after reset release
        rst = 1'b0;
        tick();
        expect_out("t1", 32'h8000_1000, 1'b0, 1'b1);

        // 2: bit 31 clears, no carry
        local_addr = 32'hFFFF_0000;
        tick();
        expect_out("t2", 32'h7FFF_0000, 1'b0, 1'b1);

        // idle: output holds, valid drops
        in_valid = 1'b0; local_addr = 32'h1111_1111;
        tick();
        expect_out("idle", 32'h7FFF_0000, 1'b0, 1'b0);

        // 3: window 0 hit
        set_win(2'd0, 1'b1, 32'h1000_0000, 32'hF000_0000, 32'h2000_0000);
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b1; local_addr = 32'h1234_5678;
        tick();
        expect_out("t3", 32'h2234_5678, 1'b1, 1'b1);
`ifdef REMAP_STATS_EN
        check("cnt.hit", hit_cnt, 32'd1);
        check("cnt.miss", miss_cnt, 32'd2);
`endif

        // cfg write and lookup in the same cycle: lookup sees the old table
        set_win(2'd2, 1'b1, 32'h5000_0000, 32'hF000_0000, 32'h6000_0000);
        local_addr = 32'h5000_0001;
        tick();
        cfg_we = 1'b0;
        expect_out("cfg_same", 32'hD000_0001, 1'b0, 1'b1);
        tick();
        expect_out("cfg_next", 32'h6000_0001, 1'b1, 1'b1);

        // 4: overlapping window 1, window 0 has priority
        in_valid = 1'b0;
        set_win(2'd1, 1'b1, 32'h1000_0000, 32'hFF00_0000, 32'h3000_0000);
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b1; local_addr = 32'h1000_0004;
        tick();
        expect_out("t4", 32'h2000_0004, 1'b1, 1'b1);

        // disabling window 0 lets window 1 take over
        in_valid = 1'b0;
        set_win(2'd0, 1'b0, 32'h1000_0000, 32'hF000_0000, 32'h2000_0000);
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b1;
        tick();
        expect_out("win1", 32'h3000_0004, 1'b1, 1'b1);

        // zero mask matches everything and passes the address through
        in_valid = 1'b0;
        set_win(2'd3, 1'b1, 32'h0, 32'h0, 32'hDEAD_BEEF);
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b1; local_addr = 32'hABCD_0123;
        tick();
        expect_out("mask0", 32'hABCD_0123, 1'b1, 1'b1);

        // 5: mid-stream reset with in_valid held high
        rst = 1'b1; local_addr = 32'h1000_0004;
        tick();
        expect_out("t5.rst", 32'h0, 1'b0, 1'b0);
`ifdef REMAP_STATS_EN
        check("cnt.hit.rst", hit_cnt, 32'd0);
        check("cnt.miss.rst", miss_cnt, 32'd0);
`endif
        rst = 1'b0; local_addr = 32'h1234_5678;
        tick();
        expect_out("t5.post", 32'h9234_5678, 1'b0, 1'b1);
`ifdef REMAP_STATS_EN
        check("cnt.miss.post", miss_cnt, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
